// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bus: run-control, redirect and LUT-programming inputs plus fetch status outputs.
interface fetch_sequencer_if #(
  parameter int PC_W      = 10,
  parameter int INSTR_W   = 9,
  parameter int TGT_IDX_W = 3
);
  logic                 start;
  logic                 stall;
  logic                 branchTaken;
  logic [TGT_IDX_W-1:0] branchIdx;
  logic                 exception;
  logic [INSTR_W-1:0]   idInstr;
  logic                 lutWrEn;
  logic [TGT_IDX_W-1:0] lutWrIdx;
  logic [PC_W-1:0]      lutWrData;
  logic [PC_W-1:0]      pc;
  logic                 fetchValid;
  logic                 flush;
  logic                 busy;
  logic                 done;

  modport master (
    output start, stall, branchTaken, branchIdx, exception, idInstr,
           lutWrEn, lutWrIdx, lutWrData,
    input  pc, fetchValid, flush, busy, done
  );

  modport slave (
    input  start, stall, branchTaken, branchIdx, exception, idInstr,
           lutWrEn, lutWrIdx, lutWrData,
    output pc, fetchValid, flush, busy, done
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and run control: IDLE/RUN/DRAIN/DONE with a programmable branch-target LUT,
// exception vector and a counted drain after a halt instruction reaches IF/ID.
module fetch_sequencer #(
  parameter int                 PC_W         = 10,
  parameter int                 INSTR_W      = 9,
  parameter int                 TGT_IDX_W    = 3,
  parameter logic [INSTR_W-1:0] HALT_OPCODE  = 9'b111000000,
  parameter int                 DRAIN_CYCLES = 3,
  parameter logic [PC_W-1:0]    EXC_VECTOR   = '0
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.slave  bus
);

  localparam int LUT_N = 1 << TGT_IDX_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} runState_t;

  runState_t       state, nextState;
  logic [PC_W-1:0] lut [LUT_N];
  logic [PC_W-1:0] pcReg;
  logic [PC_W-1:0] branchTarget;
  logic [3:0]      drainCnt;
  logic            doneReg;
  logic            inRun;
  logic            flushSig;
  logic            haltSeen;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.start) nextState = RUN;
      RUN:     if (haltSeen)  nextState = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
      DRAIN:   if (drainCnt <= 4'd1) nextState = DONE;
      DONE:    if (bus.start) nextState = RUN;
      default: nextState = IDLE;
    endcase
  end

  // A halt that is being flushed in the same cycle never retires, so it must not stop the run.
  always_comb begin
    inRun    = (state == RUN);
    flushSig = inRun & (bus.exception | bus.branchTaken);
    haltSeen = inRun & (bus.idInstr == HALT_OPCODE) & ~flushSig;
  end

  assign bus.pc         = pcReg;
  assign bus.flush      = flushSig;
  assign bus.fetchValid = inRun & ~bus.stall;
  assign bus.busy       = inRun | (state == DRAIN);
  assign bus.done       = doneReg;

  // A LUT write to the entry being branched through is forwarded so the redirect sees the new target.
  always_comb begin
    branchTarget = lut[bus.branchIdx];
    if (bus.lutWrEn && (bus.lutWrIdx == bus.branchIdx)) branchTarget = bus.lutWrData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg    <= '0;
      drainCnt <= '0;
      doneReg  <= 1'b0;
    end else begin
      doneReg <= (nextState == DONE);
      case (state)
        IDLE: pcReg <= '0;
        RUN: begin
          if (bus.exception)                 pcReg <= EXC_VECTOR;
          else if (bus.branchTaken)          pcReg <= branchTarget;
          else if (!bus.stall && !haltSeen)  pcReg <= pcReg + PC_W'(1);
          if (haltSeen) drainCnt <= 4'(DRAIN_CYCLES);
        end
        DRAIN: drainCnt <= drainCnt - 4'd1;
        DONE: if (bus.start) pcReg <= '0;
        default: pcReg <= pcReg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else if (bus.lutWrEn) begin
      lut[bus.lutWrIdx] <= bus.lutWrData;
    end
  end

endmodule
